// File: rtl/frontend_command_definition_pkg.sv
// Shared frontend command/response types: request IDs, read responses
// and the read-response buffer occupancy states.
package frontend_command_definition_pkg;

    localparam int unsigned REQ_ID_WIDTH    = 8;
    localparam int unsigned RESP_DATA_WIDTH = 128;

    typedef logic [REQ_ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        req_id_t                    id;
        logic [RESP_DATA_WIDTH-1:0] data;
    } read_resp_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } resp_buf_state_e;

endpackage

// File: rtl/read_resp_merger.sv
// Pairs backend read-data beats with queued request IDs and delivers them
// in order to the frontend through a 2-entry buffer.
module read_resp_merger
    import frontend_command_definition_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  req_id_t               i_id_data,
    input  logic                  i_id_empty,
    output logic                  o_id_rd_en,
    input  logic                  i_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_rdata_ready,
    output logic                  o_resp_valid,
    output req_id_t               o_resp_id,
    output logic [DATA_WIDTH-1:0] o_resp_data,
    input  logic                  i_resp_ready,
    output logic                  o_err_orphan,
    output logic [CNT_WIDTH-1:0]  o_resp_cnt
);

    resp_buf_state_e         state_q, state_d;
    req_id_t                 head_id_q, tail_id_q;
    logic [DATA_WIDTH-1:0]   head_data_q, tail_data_q;
    logic                    live_q;
    logic                    accept_c, push_c, orphan_c, deliver_c;
    logic                    load_head_c, load_tail_c, shift_c;

    // Handshake decode from registered state only; live_q keeps the
    // FIFO pop quiet in the first cycle out of reset.
    assign o_rdata_ready = (state_q != ST_TWO);
    assign o_resp_valid  = (state_q != ST_EMPTY);
    assign accept_c      = i_rdata_valid && o_rdata_ready && live_q;
    assign push_c        = accept_c && !i_id_empty;
    assign orphan_c      = accept_c && i_id_empty;
    assign deliver_c     = o_resp_valid && i_resp_ready;
    assign o_id_rd_en    = push_c;
    assign o_resp_id     = head_id_q;
    assign o_resp_data   = head_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_head_c = 1'b0;
        load_tail_c = 1'b0;
        shift_c     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (push_c) begin
                    load_head_c = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push_c && deliver_c) begin
                    load_head_c = 1'b1;
                end else if (push_c) begin
                    load_tail_c = 1'b1;
                    state_d     = ST_TWO;
                end else if (deliver_c) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver_c) begin
                    shift_c = 1'b1;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Buffer entries; head always drives the response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_id_q   <= '0;
            head_data_q <= '0;
            tail_id_q   <= '0;
            tail_data_q <= '0;
        end else begin
            if (shift_c) begin
                head_id_q   <= tail_id_q;
                head_data_q <= tail_data_q;
            end
            if (load_head_c) begin
                head_id_q   <= i_id_data;
                head_data_q <= i_rdata;
            end
            if (load_tail_c) begin
                tail_id_q   <= i_id_data;
                tail_data_q <= i_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_q       <= 1'b0;
            o_err_orphan <= 1'b0;
            o_resp_cnt   <= '0;
        end else begin
            live_q <= 1'b1;
            if (orphan_c) begin
                o_err_orphan <= 1'b1;
            end
            if (deliver_c) begin
                o_resp_cnt <= o_resp_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_read_resp_merger.sv
// Randomized and directed bench for read_resp_merger against a queue-based
// model of the in-order response buffer.
module tb_read_resp_merger;
    import frontend_command_definition_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef struct packed {
        req_id_t         id;
        logic [DW-1:0]   data;
    } ent_t;

    logic          clk;
    logic          rst_n;
    req_id_t       i_id_data;
    logic          i_id_empty;
    logic          o_id_rd_en;
    logic          i_rdata_valid;
    logic [DW-1:0] i_rdata;
    logic          o_rdata_ready;
    logic          o_resp_valid;
    req_id_t       o_resp_id;
    logic [DW-1:0] o_resp_data;
    logic          i_resp_ready;
    logic          o_err_orphan;
    logic [CW-1:0] o_resp_cnt;

    read_resp_merger #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_id_data     (i_id_data),
        .i_id_empty    (i_id_empty),
        .o_id_rd_en    (o_id_rd_en),
        .i_rdata_valid (i_rdata_valid),
        .i_rdata       (i_rdata),
        .o_rdata_ready (o_rdata_ready),
        .o_resp_valid  (o_resp_valid),
        .o_resp_id     (o_resp_id),
        .o_resp_data   (o_resp_data),
        .i_resp_ready  (i_resp_ready),
        .o_err_orphan  (o_err_orphan),
        .o_resp_cnt    (o_resp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: buffer contents, upstream ID FIFO, delivered count, sticky error.
    ent_t    q[$];
    req_id_t idq[$];
    int      m_cnt;
    logic    m_err;
    logic    m_live;
    int      tests;
    int      failed;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle starting and ending at a negedge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rr);
        logic acc, dlv;
        ent_t e;
        chk("resp_valid", 64'(o_resp_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("resp_id", 64'(o_resp_id), 64'(q[0].id));
            chk("resp_data", 64'(o_resp_data), 64'(q[0].data));
        end
        chk("rdata_ready", 64'(o_rdata_ready), 64'(q.size() < 2));
        chk("resp_cnt", 64'(o_resp_cnt), 64'(m_cnt));
        chk("err_orphan", 64'(o_err_orphan), 64'(m_err));
        i_rdata_valid = v;
        i_rdata       = d;
        i_resp_ready  = rr;
        i_id_empty    = (idq.size() == 0);
        i_id_data     = (idq.size() == 0) ? req_id_t'($urandom) : idq[0];
        #1;
        acc = v && (q.size() < 2) && m_live;
        dlv = (q.size() > 0) && rr;
        chk("id_rd_en", 64'(o_id_rd_en), 64'(acc && (idq.size() > 0)));
        @(posedge clk);
        if (dlv) begin
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
        if (acc) begin
            if (idq.size() > 0) begin
                e.id   = idq.pop_front();
                e.data = d;
                q.push_back(e);
            end else begin
                m_err = 1'b1;
            end
        end
        m_live = 1'b1;
        @(negedge clk);
    endtask

    // Asynchronous reset entered at a negedge; valid is held during and just after it.
    task automatic do_reset(input logic v);
        i_rdata_valid = v;
        i_id_empty    = 1'b0;
        i_id_data     = 8'h09;
        i_resp_ready  = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_cnt", 64'(o_resp_cnt), 64'd0);
        chk("rst_err", 64'(o_err_orphan), 64'd0);
        chk("rst_ready", 64'(o_rdata_ready), 64'd1);
        chk("rst_id_rd_en", 64'(o_id_rd_en), 64'd0);
        q.delete();
        idq.delete();
        m_cnt  = 0;
        m_err  = 1'b0;
        m_live = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(o_rdata_ready), 64'd1);
        chk("post_rst_id_rd_en", 64'(o_id_rd_en), 64'd0);
        @(posedge clk);
        m_live = 1'b1;
        @(negedge clk);
        i_rdata_valid = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        i_rdata = '0;
        do_reset(1'b1);
        chk("no_accept_after_rst", 64'(o_resp_valid), 64'd0);

        // Single beat
        idq.push_back(8'd5);
        cycle(1'b1, 32'hA5, 1'b0);
        chk("single_valid", 64'(o_resp_valid), 64'd1);
        chk("single_id", 64'(o_resp_id), 64'd5);
        chk("single_data", 64'(o_resp_data), 64'hA5);
        cycle(1'b0, '0, 1'b1);
        chk("single_cnt", 64'(o_resp_cnt), 64'd1);

        // Backpressure: third beat stalls until the frontend drains
        idq.push_back(8'd1);
        idq.push_back(8'd2);
        idq.push_back(8'd3);
        cycle(1'b1, 32'h11, 1'b0);
        cycle(1'b1, 32'h22, 1'b0);
        chk("bp_ready_low", 64'(o_rdata_ready), 64'd0);
        cycle(1'b1, 32'h33, 1'b0);
        chk("bp_head_id", 64'(o_resp_id), 64'd1);
        cycle(1'b1, 32'h33, 1'b1);
        chk("bp_second_id", 64'(o_resp_id), 64'd2);
        cycle(1'b1, 32'h33, 1'b1);
        chk("bp_third_id", 64'(o_resp_id), 64'd3);
        chk("bp_third_data", 64'(o_resp_data), 64'h33);
        cycle(1'b0, '0, 1'b1);
        chk("bp_cnt", 64'(o_resp_cnt), 64'd4);

        // Streaming through ONE with simultaneous push and deliver
        for (int i = 0; i < 8; i++) idq.push_back(req_id_t'(8'h40 + i));
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, DW'($urandom), 1'b1);
            chk("stream_one", 64'({o_resp_valid, o_rdata_ready}), 64'd3);
        end
        cycle(1'b0, '0, 1'b1);

        // Orphan beat
        cycle(1'b1, 32'hFF, 1'b1);
        chk("orphan_err", 64'(o_err_orphan), 64'd1);
        chk("orphan_no_resp", 64'(o_resp_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 3) == 0 && idq.size() < 4) idq.push_back(req_id_t'($urandom));
            cycle(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0);
        end
        chk("orphan_sticky", 64'(o_err_orphan), 64'd1);

        // Reset while the buffer is full
        while (q.size() > 0) cycle(1'b0, '0, 1'b1);
        idq.push_back(8'd7);
        idq.push_back(8'd8);
        cycle(1'b1, 32'h77, 1'b0);
        cycle(1'b1, 32'h88, 1'b0);
        chk("pre_rst_full", 64'(o_rdata_ready), 64'd0);
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("no_stale_resp", 64'(o_resp_valid), 64'd0);
        end

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 17; i++) idq.push_back(req_id_t'(i));
        for (int i = 0; i < 17; i++) cycle(1'b1, DW'($urandom), 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("cnt_wrap", 64'(o_resp_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
